// File: rtl/input_conditioner.sv
// Per-bit raw-input conditioner: two-flop synchroniser, stable-count debouncer,
// registered clean level plus single-cycle rise/fall strobes.
//
// Per-bit debounce state (implicit, no state register):
//   state    | meaning
//   IDLE     | sync2 == level, counter held at 0
//   COUNTING | sync2 != level, counter advancing toward terminal count
module input_conditioner #(
    parameter int width         = 10,
    parameter int stable_cycles = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] raw,
    output logic [width-1:0] level,
    output logic [width-1:0] rise,
    output logic [width-1:0] fall
);

    localparam int CNT_W_RAW = $clog2(stable_cycles + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(stable_cycles - 1);

    logic [width-1:0] sync1_q, sync1_d;
    logic [width-1:0] sync2_q, sync2_d;
    logic [width-1:0] level_q, level_d;
    logic [width-1:0] rise_q,  rise_d;
    logic [width-1:0] fall_q,  fall_d;
    logic [CNT_W-1:0] cnt_q [width];
    logic [CNT_W-1:0] cnt_d [width];

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < width; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == TERM) begin
                    level_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < width; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < width; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized checks of input_conditioner against a sliding-window
// reference model of the raw sample history.
module tb_input_conditioner;

    localparam int W  = 10;
    localparam int SC = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int total;
    int bad;

    input_conditioner #(.width(W), .stable_cycles(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: raw samples since the last reset; a sample taken at edge n
    // reaches the decision at edge n+2. Accept when the last SC decision
    // samples all disagree with the current level.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_level;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;

    function automatic logic [W-1:0] sample_at(int idx);
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] all_one;
        logic [W-1:0] all_zero;
        logic [W-1:0] v;
        int n;
        if (!rst_n) begin
            hist.delete();
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            hist.push_back(raw);
            n        = hist.size() - 1;
            all_one  = '1;
            all_zero = '1;
            for (int j = 0; j < SC; j++) begin
                v        = sample_at(n - 2 - j);
                all_one  = all_one & v;
                all_zero = all_zero & ~v;
            end
            m_rise  = all_one & ~m_level;
            m_fall  = all_zero & m_level;
            m_level = (m_level | m_rise) & ~m_fall;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs for the next rising edge, then check just after it on the falling edge.
    task automatic tick(input logic [W-1:0] r, input logic rn);
        raw   = r;
        rst_n = rn;
        @(negedge clk);
        chk("model_level", level, m_level);
        chk("model_rise",  rise,  m_rise);
        chk("model_fall",  fall,  m_fall);
        chk("rise_and_fall_exclusive", rise & fall, '0);
    endtask

    task automatic hold(input logic [W-1:0] r, input int n);
        for (int i = 0; i < n; i++) tick(r, 1'b1);
    endtask

    initial begin
        logic [W-1:0] rv;
        total = 0;
        bad   = 0;
        raw   = '0;
        rst_n = 1'b0;

        // 1: reset with all inputs high
        for (int i = 0; i < 3; i++) begin
            tick(10'h3FF, 1'b0);
            chk("reset_level", level, '0);
            chk("reset_rise",  rise,  '0);
            chk("reset_fall",  fall,  '0);
        end
        tick(10'h3FF, 1'b1);
        for (int i = 1; i < 5; i++) begin
            tick(10'h3FF, 1'b1);
            chk("post_reset_level_pending", level, '0);
        end
        tick(10'h3FF, 1'b1);
        chk("post_reset_level", level, 10'h3FF);
        chk("post_reset_rise",  rise,  10'h3FF);
        tick(10'h3FF, 1'b1);
        chk("post_reset_rise_clear", rise, '0);

        // 2: clean step on bit 0
        hold('0, 10);
        chk("step_pre_level", level, '0);
        tick(10'h001, 1'b1);
        for (int i = 1; i < 5; i++) begin
            tick(10'h001, 1'b1);
            chk("step_pending", level, '0);
        end
        tick(10'h001, 1'b1);
        chk("step_level", level, 10'h001);
        chk("step_rise",  rise,  10'h001);
        tick(10'h001, 1'b1);
        chk("step_rise_clear", rise, '0);
        for (int i = 0; i < 5; i++) begin
            tick(10'h001, 1'b1);
            chk("step_hold", level, 10'h001);
        end

        // 3: glitch rejection, pulse lengths 1, 3 (filtered) and 4 (accepted)
        hold('0, 10);
        tick(10'h001, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick('0, 1'b1);
            chk("glitch1_level", level, '0);
            chk("glitch1_rise",  rise,  '0);
        end
        hold(10'h001, 3);
        for (int i = 0; i < 7; i++) begin
            tick('0, 1'b1);
            chk("glitch3_level", level, '0);
            chk("glitch3_rise",  rise,  '0);
        end
        hold(10'h001, 4);
        tick('0, 1'b1);
        chk("pulse4_pending", level, '0);
        tick('0, 1'b1);
        chk("pulse4_level", level, 10'h001);
        chk("pulse4_rise",  rise,  10'h001);
        hold('0, 8);
        chk("pulse4_settled", level, '0);

        // 4: simultaneous opposite transitions
        hold(10'h200, 8);
        chk("opp_start", level, 10'h200);
        tick(10'h001, 1'b1);
        hold(10'h001, 4);
        tick(10'h001, 1'b1);
        chk("opp_level", level, 10'h001);
        chk("opp_rise",  rise,  10'h001);
        chk("opp_fall",  fall,  10'h200);
        tick(10'h001, 1'b1);
        chk("opp_rise_clear", rise, '0);
        chk("opp_fall_clear", fall, '0);

        // 5: reset in the middle of a count
        hold('0, 8);
        tick(10'h008, 1'b1);
        tick(10'h008, 1'b1);
        tick(10'h008, 1'b1);
        tick(10'h008, 1'b0);
        chk("midreset_level", level, '0);
        chk("midreset_rise",  rise,  '0);
        tick(10'h008, 1'b1);
        for (int i = 1; i < 5; i++) begin
            tick(10'h008, 1'b1);
            chk("midreset_pending", level & 10'h008, '0);
            chk("midreset_no_rise", rise & 10'h008, '0);
        end
        tick(10'h008, 1'b1);
        chk("midreset_level_after", level, 10'h008);
        chk("midreset_rise_after",  rise,  10'h008);

        // 6: bounce train on bit 5
        hold('0, 8);
        for (int t = 0; t < 20; t++) begin
            tick(((t / 2) % 2 == 0) ? 10'h020 : 10'h000, 1'b1);
            chk("bounce_level", level & 10'h020, '0);
            chk("bounce_rise",  rise  & 10'h020, '0);
            chk("bounce_fall",  fall  & 10'h020, '0);
        end
        for (int t = 0; t < 8; t++) begin
            tick('0, 1'b1);
            chk("bounce_settle", level & 10'h020, '0);
        end

        // Randomized: sparse bit flips with occasional short bursts and resets
        rv = '0;
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 3) == 0)
                rv = rv ^ W'($urandom & $urandom & $urandom);
            tick(rv, ($urandom_range(0, 149) != 0));
        end
        hold(rv, 10);
        chk("random_final_level", level, rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
